// File: rtl/exe_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide execute unit: shift-add multiplier
// retiring MUL_BITS per cycle, restoring radix-2 divider, one-cycle fast path.
module exe_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int NB_REGS  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_v_i,
  input  logic [2:0]         op_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [NB_REGS-1:0] rd_adr_i,
  input  logic               flush_i,
  output logic               req_rdy_o,
  output logic               busy_o,
  output logic               res_v_q_o,
  output logic [XLEN-1:0]    res_data_q_o,
  output logic [NB_REGS-1:0] res_adr_q_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_CNT = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0]   DIV_CNT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic [1:0]          r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [NB_REGS-1:0]  r_adr;
  logic [XLEN-1:0]     r_res_data;
  logic [NB_REGS-1:0]  r_res_adr;

  logic                w_accept, w_is_mul, w_s1, w_s2, w_neg1, w_neg2;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic                w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]     w_fast_res;
  logic                w_last;

  assign w_accept   = req_v_i & (r_state == S_IDLE) & ~flush_i;
  assign w_is_mul   = ~op_i[2];
  assign w_s1       = (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
  assign w_s2       = (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
  assign w_neg1     = w_s1 & rs1_data_i[XLEN-1];
  assign w_neg2     = w_s2 & rs2_data_i[XLEN-1];
  assign w_mag1     = w_neg1 ? (-rs1_data_i) : rs1_data_i;
  assign w_mag2     = w_neg2 ? (-rs2_data_i) : rs2_data_i;
  assign w_div_zero = ~w_is_mul & (rs2_data_i == ZERO_X);
  assign w_ovf      = ~w_is_mul & ~op_i[0] & (rs1_data_i == MIN_X) & (rs2_data_i == ONES_X);
  assign w_fast     = w_div_zero | w_ovf;
  assign w_fast_res = w_div_zero ? (op_i[1] ? rs1_data_i : ONES_X)
                                 : (op_i[1] ? ZERO_X : rs1_data_i);
  assign w_last     = (r_cnt == CNT_ONE);

  // Multiplier step: add multiplicand * next digit into the upper half, shift right.
  logic [XLEN+MUL_BITS-1:0] w_pp, w_mul_sum;
  logic [2*XLEN-1:0]        w_mul_next, w_prod_s;
  logic [XLEN-1:0]          w_mul_res;

  assign w_pp       = {{MUL_BITS{1'b0}}, r_opb} * {{XLEN{1'b0}}, r_acc[MUL_BITS-1:0]};
  assign w_mul_sum  = {{MUL_BITS{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:MUL_BITS]};
  assign w_prod_s   = r_neg_q ? (-w_mul_next) : w_mul_next;
  assign w_mul_res  = (r_op == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

  // Divider step: upper half is the partial remainder, lower half the dividend/quotient.
  logic [XLEN:0]   w_div_sh, w_div_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_n, w_quo_n, w_div_res;

  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_ge       = ~w_div_diff[XLEN];
  assign w_rem_n    = w_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
  assign w_quo_n    = {r_acc[XLEN-2:0], w_ge};
  assign w_div_res  = r_op[1] ? (r_neg_r ? (-w_rem_n) : w_rem_n)
                              : (r_neg_q ? (-w_quo_n) : w_quo_n);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush wins over counter completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fast) begin
            w_next = S_DONE;
          end else if (w_is_mul) begin
            w_next = S_MUL;
          end else begin
            w_next = S_DIV;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = r_state;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= {CW{1'b0}};
      r_acc      <= {(2*XLEN){1'b0}};
      r_opb      <= ZERO_X;
      r_op       <= 2'b00;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_adr      <= {NB_REGS{1'b0}};
      r_res_data <= ZERO_X;
      r_res_adr  <= {NB_REGS{1'b0}};
    end else if (w_accept) begin
      r_op    <= op_i[1:0];
      r_adr   <= rd_adr_i;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      r_cnt   <= w_is_mul ? MUL_CNT : DIV_CNT;
      r_acc   <= {ZERO_X, (w_is_mul ? w_mag2 : w_mag1)};
      r_opb   <= w_is_mul ? w_mag1 : w_mag2;
      if (w_fast) begin
        r_res_data <= w_fast_res;
        r_res_adr  <= rd_adr_i;
      end
    end else if ((r_state == S_MUL) && !flush_i) begin
      r_acc <= w_mul_next;
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_res_data <= w_mul_res;
        r_res_adr  <= r_adr;
      end
    end else if ((r_state == S_DIV) && !flush_i) begin
      r_acc <= {w_rem_n, w_quo_n};
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_res_data <= w_div_res;
        r_res_adr  <= r_adr;
      end
    end
  end

  assign req_rdy_o    = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign res_v_q_o    = (r_state == S_DONE) & ~flush_i;
  assign res_data_q_o = r_res_data;
  assign res_adr_q_o  = r_res_adr;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed + randomized bench for exe_muldiv (XLEN=32, MUL_BITS=4) against an
// arithmetic reference model.
module tb_exe_muldiv;

  localparam int XLEN = 32;
  localparam int MB   = 4;
  localparam int NR   = 5;

  logic            clk = 1'b0;
  logic            reset_n, req_v_i, flush_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic [NR-1:0]   rd_adr_i;
  logic            req_rdy_o, busy_o, res_v_q_o;
  logic [XLEN-1:0] res_data_q_o;
  logic [NR-1:0]   res_adr_q_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(XLEN), .MUL_BITS(MB), .NB_REGS(NR)) dut (
    .clk(clk), .reset_n(reset_n), .req_v_i(req_v_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_adr_i(rd_adr_i),
    .flush_i(flush_i), .req_rdy_o(req_rdy_o), .busy_o(busy_o),
    .res_v_q_o(res_v_q_o), .res_data_q_o(res_data_q_o), .res_adr_q_o(res_adr_q_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return op[2] ? XLEN : XLEN / MB;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request from a negedge, follow it to completion, end at a negedge in IDLE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [NR-1:0] adr, input bit fl_done);
    int k;
    int n;
    logic [31:0] exp;
    exp = ref_res(op, a, b);
    n   = ref_lat(op, a, b);
    k   = 0;
    while (!req_rdy_o && k < 100) begin @(negedge clk); k++; end
    check("rdy_before", req_rdy_o, 64'd1);
    req_v_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_adr_i = adr;
    @(posedge clk);
    @(negedge clk);
    req_v_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom; rd_adr_i = NR'($urandom);
    k = 1;
    while (!res_v_q_o && k < 100) begin
      check("busy", busy_o, 64'd1);
      @(negedge clk);
      k++;
    end
    check("latency", k, n + 1);
    check("data", res_data_q_o, exp);
    check("adr", res_adr_q_o, adr);
    check("busy_done", busy_o, 64'd1);
    if (fl_done) begin
      flush_i = 1'b1;
      #1;
      check("flush_done_v", res_v_q_o, 64'd0);
    end
    @(negedge clk);
    flush_i = 1'b0;
    check("pulse", res_v_q_o, 64'd0);
    check("rdy_after", req_rdy_o, 64'd1);
    check("hold", res_data_q_o, exp);
  endtask

  initial begin
    reset_n = 1'b0; req_v_i = 1'b0; flush_i = 1'b0; op_i = 3'd0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; rd_adr_i = 5'd0;
    #1;
    check("rst_rdy", req_rdy_o, 64'd1);
    check("rst_busy", busy_o, 64'd0);
    check("rst_v", res_v_q_o, 64'd0);
    check("rst_data", res_data_q_o, 64'd0);
    check("rst_adr", res_adr_q_o, 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 5'd16, 1'b0);
    run_op(3'd0, 32'd3, 32'd4, 5'd13, 1'b1);

    // Flush during DIV at t+10, then a MUL accepted at t+11.
    req_v_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_adr_i = 5'd14;
    @(posedge clk);
    @(negedge clk);
    req_v_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("div_no_v", res_v_q_o, 64'd0);
      @(negedge clk);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_v", res_v_q_o, 64'd0);
    check("flush_rdy", req_rdy_o, 64'd1);
    check("flush_busy", busy_o, 64'd0);
    run_op(3'd0, 32'd12345, 32'd678, 5'd15, 1'b0);

    // Request together with flush in IDLE is dropped.
    req_v_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd5; rs2_data_i = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("drop_rdy", req_rdy_o, 64'd1);
    check("drop_busy", busy_o, 64'd0);
    req_v_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("drop_v", res_v_q_o, 64'd0);

    // Reset in the middle of a multiply.
    req_v_i = 1'b1; op_i = 3'd3; rs1_data_i = $urandom; rs2_data_i = $urandom; rd_adr_i = 5'd17;
    @(posedge clk);
    @(negedge clk);
    req_v_i = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_rdy", req_rdy_o, 64'd1);
    check("mrst_busy", busy_o, 64'd0);
    check("mrst_v", res_v_q_o, 64'd0);
    check("mrst_data", res_data_q_o, 64'd0);
    check("mrst_adr", res_adr_q_o, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'd5, $urandom, $urandom_range(1, 1000), 5'd18, 1'b0);
    run_op(3'd5, $urandom, $urandom, 5'd19, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), NR'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide extension. It sits beside the single-cycle ALU, shifter, BU and LSU in the execute stage, fed from decode with qualified operands. The pipeline holds while busy_o is high. The result is presented to write-back as a registered, single-cycle valid pulse with a destination register address. A branch flush aborts an in-flight operation.

Parameters:
XLEN, 32, operand and result width; legal values 32 or 64.
MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8; must divide XLEN.
NB_REGS, 5, width of the destination register address.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_v_i  in  1  operation request valid
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data_i  in  XLEN  operand 1 (dividend / multiplicand)
rs2_data_i  in  XLEN  operand 2 (divisor / multiplier)
rd_adr_i  in  NB_REGS  destination register
flush_i  in  1  branch flush; aborts the current and any presented request
req_rdy_o  out  1  unit can accept a request (state IDLE)
busy_o  out  1  operation in flight (state MUL, DIV or DONE); decode stall
res_v_q_o  out  1  result valid pulse to write-back
res_data_q_o  out  XLEN  result data
res_adr_q_o  out  NB_REGS  result destination

Behaviour:
- Reset (asynchronous): state IDLE, counter 0. All outputs 0 except req_rdy_o = 1. All internal accumulators are cleared.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: a request is accepted when req_v_i & req_rdy_o & ~flush_i. A request presented together with flush_i is dropped.
- On accept, the unit latches op, rd_adr and operand magnitudes, plus sign flags for the result and the remainder.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV, REM: both operands signed.
  - MUL, MULHU, DIVU, REMU: operands unsigned.
- Accept transitions:
  - IDLE -> MUL for op 0-3, counter = XLEN/MUL_BITS.
  - IDLE -> DIV for op 4-7, counter = XLEN.
  - IDLE -> DONE (fast path) for division by zero or signed overflow.
- MUL state: shift-add on a 2*XLEN-bit accumulator, MUL_BITS multiplier bits per cycle. The counter decrements each cycle; at 1 the FSM moves to DONE. The final result is conditionally negated (2*XLEN-bit two's complement). Result selection:
  - MUL: low XLEN bits.
  - MULH, MULHSU, MULHU: high XLEN bits.
- DIV state: restoring radix-2 algorithm, one quotient bit per cycle, XLEN cycles. The quotient is negated if the operand signs differ (signed ops). The remainder takes the sign of the dividend.
- Fast path, division by zero:
  - quotient = all ones.
  - remainder = rs1.
- Fast path, signed overflow (DIV/REM with rs1 = most-negative and rs2 = -1):
  - quotient = rs1.
  - remainder = 0.
- DONE state: lasts exactly one cycle; res_v_q_o = 1 and res_data_q_o/res_adr_q_o are valid; then DONE -> IDLE. res_data_q_o holds its value until the next DONE.
- Latency: a request accepted in cycle t gives res_v_q_o high in cycle t+N+1.
  - N = XLEN/MUL_BITS for multiplies.
  - N = XLEN for divides.
  - N = 0 for the fast path.
- Throughput: req_rdy_o is high only in IDLE. Minimum spacing between two accepts is N+2 cycles.
- Flush:
  - flush_i in MUL or DIV: the next state is IDLE, with no res_v_q_o.
  - flush_i in DONE: res_v_q_o is suppressed for that cycle (output gated combinationally with ~flush_i); the FSM returns to IDLE.
- flush_i has priority over counter completion.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.

Test Plan:
- XLEN=32, MUL_BITS=1: MUL rs1=7, rs2=0xFFFFFFFD accepted at t -> res_v_q_o at t+33, data 0xFFFFFFEB, res_adr_q_o = rd_adr_i (e.g. 5).
- MUL_BITS=4, MULH 0x80000000 x 0x80000000 -> data 0x40000000 at t+9. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at t+33; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path: DIVU 5/0 -> 0xFFFFFFFF at t+1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at t+1; REM with the same operands -> 0. busy_o is high for exactly 1 cycle.
- Flush: DIV accepted at t, flush_i at t+10 -> no res_v_q_o; req_rdy_o = 1 at t+11; a new MUL accepted at t+11 completes correctly. A request presented with flush_i=1 in IDLE is not accepted.
- reset_n dropped at t+5 during MUL -> all outputs 0 and req_rdy_o = 1 immediately; after release, back-to-back DIVU requests complete at t'+33 and t'+67.
